// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: sequential instruction fetch with req/ack memory port, prefetch FIFO and redirect flush.
// Optional stall counter output perf_stall_cnt is built when IFETCH_PERF_CNT_EN is defined.
module ifetch_prefetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   input  logic                     mem_ack,
   input  logic [31:0]              mem_rdata,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     inst_valid,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   input  logic                     inst_ready,
   output logic [$clog2(DEPTH):0]   fifo_count
`ifdef IFETCH_PERF_CNT_EN
   ,output logic [31:0]             perf_stall_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2;
   logic [1:0]    state;
   logic [31:0]   fetch_pc;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   pc_q [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count, count_after;
   logic          push, pop;
   logic [31:0]   target, next_pc;
   assign target      = redirect_pc & 32'hFFFF_FFFC;
   assign next_pc     = fetch_pc + 32'd4;
   assign push        = (state == WAIT) && mem_ack && !redirect_valid;
   assign pop         = inst_valid && inst_ready && !redirect_valid;
   assign count_after = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign inst_valid  = count != '0;
   assign inst        = data_q[rd_ptr];
   assign inst_pc     = pc_q[rd_ptr];
   assign fifo_count  = count;
   // Fetch FSM: one outstanding request; a redirect with the request still open waits out its ack in DISCARD
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= target;
         if (state != IDLE && !mem_ack) begin
            state <= DISCARD;
         end else begin
            state    <= WAIT;
            mem_req  <= 1'b1;
            mem_addr <= target;
         end
      end else begin
         case (state)
            IDLE: if (count != FULL) begin
               state    <= WAIT;
               mem_req  <= 1'b1;
               mem_addr <= fetch_pc;
            end
            WAIT: if (mem_ack) begin
               fetch_pc <= next_pc;
               mem_addr <= next_pc;
               if (count_after == FULL) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            DISCARD: if (mem_ack) begin
               state    <= WAIT;
               mem_addr <= fetch_pc;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end
   // Prefetch FIFO storage and pointers; a redirect empties it and drops any same-cycle push or pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= fetch_pc;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count_after;
      end
   end
`ifdef IFETCH_PERF_CNT_EN
   // Saturating count of cycles spent waiting on memory; survives redirects
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) perf_stall_cnt <= '0;
      else if (mem_req && !mem_ack && perf_stall_cnt != 32'hFFFF_FFFF) perf_stall_cnt <= perf_stall_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb_ifetch_prefetch_unit: directed scoreboard bench for ifetch_prefetch_unit (main instance plus a wrap-around instance).
module tb_ifetch_prefetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        reset, mem_req, mem_ack, redirect_valid, inst_valid, inst_ready;
   logic [31:0] mem_addr, mem_rdata, redirect_pc, inst, inst_pc;
   logic [2:0]  fifo_count;
   logic        reset2, mem_req2, mem_ack2, redirect_valid2, inst_valid2, inst_ready2;
   logic [31:0] mem_addr2, mem_rdata2, redirect_pc2, inst2, inst_pc2;
   logic [2:0]  fifo_count2;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_stall_cnt2;
`endif
   int          n_checks = 0, n_fail = 0;
   logic        ack_en;
   int          ack_delay;
   logic [63:0] sb_q[$];
   logic [63:0] sb2_q[$];

   ifetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .fifo_count(fifo_count)
`ifdef IFETCH_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   ifetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2),
      .mem_rdata(mem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
      .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_ready(inst_ready2),
      .fifo_count(fifo_count2)
`ifdef IFETCH_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt2)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      redirect_valid = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   // Memory model for the main instance: ack after ack_delay waiting cycles, data derived from the address
   initial begin
      int wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!reset) begin
            mem_ack = 1'b0;
            wcnt = 0;
         end else if (mem_req && ack_en && wcnt >= ack_delay) begin
            mem_ack = 1'b1;
            mem_rdata = mem_word(mem_addr);
            wcnt = 0;
         end else begin
            mem_ack = 1'b0;
            if (mem_req) wcnt++;
         end
      end
   end

   // Memory model for the wrap instance: zero-latency ack
   initial begin
      mem_ack2 = 1'b0;
      mem_rdata2 = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_ack2 = mem_req2;
         mem_rdata2 = mem_word(mem_addr2);
      end
   end

   // Monitors: every accepted instruction is compared against the head of its scoreboard queue
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (reset && inst_valid && inst_ready && !redirect_valid) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pop: got pc %h expected no pop", inst_pc);
            end else begin
               e = sb_q.pop_front();
               check("pop_pc", inst_pc, e[63:32]);
               check("pop_inst", inst, e[31:0]);
            end
         end
      end
   end

   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (reset2 && inst_valid2 && inst_ready2) begin
            if (sb2_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pop2: got pc %h expected no pop", inst_pc2);
            end else begin
               e = sb2_q.pop_front();
               check("pop2_pc", inst_pc2, e[63:32]);
               check("pop2_inst", inst2, e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int k;
      reset = 1'b0; reset2 = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
      inst_ready = 1'b0; inst_ready2 = 1'b0;
      ack_en = 1'b1; ack_delay = 0;
      step(2);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_count", fifo_count, 0);
      check("rst2_mem_addr", mem_addr2, 32'hFFFF_FFF8);
      // Sequential fetch with ack and ready every cycle
      for (int i = 0; i < 4; i++) sb_q.push_back({32'(i * 4), mem_word(32'(i * 4))});
      inst_ready = 1'b1;
      reset = 1'b1;
      check("t1_req_c1", mem_req, 0);
      step();
      check("t1_req_c2", mem_req, 1);
      check("t1_addr_c2", mem_addr, 0);
      check("t1_valid_c2", inst_valid, 0);
      step();
      check("t1_valid_c3", inst_valid, 1);
      check("t1_pc_c3", inst_pc, 0);
      step(4);
      inst_ready = 1'b0;
      // FIFO full stall, then a single pop
      do_reset();
      k = 0;
      while (fifo_count != 3'd4 && k < 20) begin step(); k++; end
      check("t2_full_count", fifo_count, 4);
      check("t2_req_drop", mem_req, 0);
      step(2);
      check("t2_hold_count", fifo_count, 4);
      check("t2_hold_req", mem_req, 0);
      sb_q.push_back({32'h0, mem_word(32'h0)});
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      check("t2_count3", fifo_count, 3);
      k = 0;
      while (!mem_req && k < 5) begin step(); k++; end
      check("t2_req_again", mem_req, 1);
      check("t2_addr16", mem_addr, 32'h10);
      // Redirect while a slow request is in flight
      ack_delay = 3;
      do_reset();
      step(2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      step();
      redirect_valid = 1'b0;
      check("t3_req_held", mem_req, 1);
      check("t3_addr_held", mem_addr, 0);
      check("t3_count0", fifo_count, 0);
      step(2);
      check("t3_req_target", mem_req, 1);
      check("t3_addr_target", mem_addr, 32'h100);
      check("t3_nothing_pushed", fifo_count, 0);
      k = 0;
      while (!inst_valid && k < 20) begin step(); k++; end
      check("t3_valid", inst_valid, 1);
      check("t3_first_pc", inst_pc, 32'h100);
      sb_q.push_back({32'h100, mem_word(32'h100)});
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      ack_delay = 0;
      // Redirect coinciding with mem_ack and a pop
      do_reset();
      step(3);
      check("t4_pre_count", fifo_count, 2);
      redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
      step();
      redirect_valid = 1'b0; inst_ready = 1'b0;
      check("t4_count0", fifo_count, 0);
      check("t4_valid0", inst_valid, 0);
      check("t4_req", mem_req, 1);
      check("t4_addr", mem_addr, 32'h40);
      step();
      check("t4_valid", inst_valid, 1);
      check("t4_pc", inst_pc, 32'h40);
      sb_q.push_back({32'h40, mem_word(32'h40)});
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      // PC wrap on the second instance
      sb2_q.push_back({32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8)});
      sb2_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
      sb2_q.push_back({32'h0000_0000, mem_word(32'h0000_0000)});
      inst_ready2 = 1'b1;
      reset2 = 1'b1;
      step(5);
      inst_ready2 = 1'b0;
      reset2 = 1'b0;
      // Asynchronous reset in the middle of a stalled request
      ack_en = 1'b0;
      do_reset();
      step(6);
      check("t6_req_before", mem_req, 1);
`ifdef IFETCH_PERF_CNT_EN
      check("t6_perf_before", perf_stall_cnt, 5);
`endif
      #2;
      reset = 1'b0;
      #1;
      check("t6_req", mem_req, 0);
      check("t6_valid", inst_valid, 0);
      check("t6_count", fifo_count, 0);
      check("t6_addr", mem_addr, 0);
`ifdef IFETCH_PERF_CNT_EN
      check("t6_perf", perf_stall_cnt, 0);
`endif
      step(2);
      check("sb_drained", sb_q.size(), 0);
      check("sb2_drained", sb2_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
